cic_decimator: RTL
==================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 The block SHALL have parameter DEC_RATE, default 64, giving the decimation ratio R; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have localparam OUT_W, equal to 2 + 3*log2(DEC_RATE) (20 at default), giving the output word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: run enable; low holds the block in IDLE.
REQ-006 The block SHALL have port din, input, 1 bit: modulator bitstream; 1 means +1, 0 means -1.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din is sampled on a clk edge only when din_valid is high.
REQ-008 The block SHALL have port dout, output, OUT_W bits: signed two's-complement decimated word.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout holds a word.
REQ-010 The block SHALL have port dout_ready, input, 1 bit: downstream accepts dout.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.

Function
REQ-012 The block SHALL implement a third-order CIC filter (three integrators, three combs, differential delay 1), with every register OUT_W bits wide and wrapping modulo 2^OUT_W.
REQ-013 FSM states SHALL be IDLE, SETTLE and RUN.
- IDLE to SETTLE: on en high.
- Any state to IDLE: on the clk edge where en is low.
REQ-014 In IDLE the block SHALL clear the integrators, combs, decimation counter, settle counter, FIFO and overflow, and SHALL ignore din_valid.
REQ-015 In SETTLE and RUN, each accepted sample SHALL update all three integrators in the same cycle, and SHALL advance the decimation counter, which counts 0..DEC_RATE-1 and wraps.
REQ-016 On the sample that moves the counter from DEC_RATE-1 to 0 (the decimation tick), the third integrator value including that sample SHALL be registered into the comb input on the following edge.
REQ-017 The comb chain SHALL produce its result one edge after the comb input is registered, so a word is pushed into the FIFO two clk edges after the tick edge.
REQ-018 SETTLE SHALL discard the first 3 comb results, then move to RUN; RUN SHALL push every comb result.
REQ-019 The output FIFO SHALL be 2 entries deep.
- dout_valid equals not-empty; dout shows the head entry.
- Pop on dout_valid and dout_ready.
REQ-020 When the FIFO is full, a push in the same cycle as a pop SHALL be accepted.
REQ-021 When the FIFO is full, a push with no pop SHALL drop the new word and set overflow; the stored words SHALL be unchanged.
REQ-022 overflow SHALL clear only on reset or IDLE.
REQ-023 A decimation tick on consecutive clk edges (R samples every R clocks) SHALL be sustainable without loss when dout_ready is held high.
REQ-024 dout SHALL be held stable while dout_valid is high and dout_ready is low.

Reset
REQ-025 While reset is high, on each clk edge the block SHALL enter IDLE with dout=0, dout_valid=0 and overflow=0, and all internal registers cleared.
REQ-026 Reset SHALL take priority over en, din_valid and dout_ready; a word in flight mid-operation SHALL be discarded.

Structure
REQ-027 Package cic_pkg SHALL hold the FSM state enum, the constants CIC_ORDER=3 and SETTLE_WORDS=3, and a function returning OUT_W from DEC_RATE.
REQ-028 The 2-entry output buffer SHALL be a sub-module named cic_out_fifo, carrying the valid/ready, full/empty and overflow-detect logic.
REQ-029 The integrator and comb datapath SHALL remain in cic_decimator.

Verification
REQ-030 Scenario: DEC_RATE=64, en=1, din_valid=1 every clk, din=1 constant -> first dout_valid after 4 ticks, then every RUN word equals +262144.
REQ-031 Scenario: same setup, din=0 constant -> every RUN word equals -262144.
REQ-032 Scenario: din repeating 1,1,1,0 -> every RUN word equals +131072; din alternating 1,0 -> every RUN word equals 0.
REQ-033 Scenario: dout_ready=0 through 3 RUN ticks -> 2 words held with dout stable, third word dropped, overflow=1; then dout_ready=1 -> both held words drain in order and overflow stays 1.
REQ-034 Scenario: din_valid high one cycle in three -> ticks every 192 clk, values identical to REQ-030.
REQ-035 Scenario: reset or en=0 asserted mid-RUN with the FIFO holding 1 word -> next edge dout_valid=0 and overflow=0; on re-enable, 3 words are discarded again before output resumes.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and constants for the third-order CIC decimator.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } cic_state_e;

  localparam int CIC_ORDER    = 3;
  localparam int SETTLE_WORDS = 3;

  // Bit growth of an order-N CIC with unit differential delay, plus sign and input bit.
  function automatic int cic_out_width(input int dec_rate);
    return 2 + CIC_ORDER * $clog2(dec_rate);
  endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Two-entry output buffer with valid/ready handshake and sticky drop detection.
module cic_out_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         overflow_q;
  logic         empty_s;
  logic         full_s;
  logic         pop_s;
  logic         wr_s;
  logic         drop_s;

  // A full buffer still takes a push when the head leaves on the same edge.
  always_comb begin
    empty_s = (count_q == 2'd0);
    full_s  = (count_q == 2'd2);
    pop_s   = !empty_s && ready_i;
    wr_s    = push_i && (!full_s || pop_s);
    drop_s  = push_i && full_s && !pop_s;
  end

  // Storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign valid_o    = !empty_s;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/cic_decimator.sv
// Third-order CIC decimator for a 1-bit modulator stream, with settle-discard
// of start-up words and a two-entry output buffer.
module cic_decimator
  import cic_pkg::*;
#(
  parameter  int DEC_RATE = 64,
  localparam int OUT_W    = cic_out_width(DEC_RATE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DEC_RATE);

  cic_state_e       state_q, state_d;
  logic [1:0]       settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] dec_cnt_q;
  logic [OUT_W-1:0] int1_q, int2_q, int3_q;
  logic [OUT_W-1:0] int1_d, int2_d, int3_d;
  logic [OUT_W-1:0] comb_in_q, dly1_q, dly2_q, dly3_q;
  logic [OUT_W-1:0] c1_s, c2_s, c3_s, samp_s;
  logic             tick_q, comb_vld_q;
  logic             clear_s, accept_s, push_s;

  // Integrators cascade within one cycle so the tick sees the sample that caused it.
  always_comb begin
    samp_s = din ? OUT_W'(1) : {OUT_W{1'b1}};
    int1_d = int1_q + samp_s;
    int2_d = int2_q + int1_d;
    int3_d = int3_q + int2_d;
    c1_s   = comb_in_q - dly1_q;
    c2_s   = c1_s - dly2_q;
    c3_s   = c2_s - dly3_q;
  end

  // Next state, settle counting and FIFO push qualification.
  always_comb begin
    clear_s      = (state_q == ST_IDLE) || !en;
    accept_s     = !clear_s && din_valid;
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    push_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_SETTLE;
        else    state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (comb_vld_q) begin
          if (settle_cnt_q == 2'(SETTLE_WORDS - 1)) begin
            state_d      = ST_RUN;
            settle_cnt_d = 2'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 2'd1;
          end
        end else begin
          settle_cnt_d = settle_cnt_q;
        end
      end
      ST_RUN:  push_s = comb_vld_q;
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d      = ST_IDLE;
      settle_cnt_d = 2'd0;
      push_s       = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Integrators, decimation counter and the two-stage comb pipeline.
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      int1_q     <= '0;
      int2_q     <= '0;
      int3_q     <= '0;
      dec_cnt_q  <= '0;
      tick_q     <= 1'b0;
      comb_vld_q <= 1'b0;
      comb_in_q  <= '0;
      dly1_q     <= '0;
      dly2_q     <= '0;
      dly3_q     <= '0;
    end else begin
      if (accept_s) begin
        int1_q    <= int1_d;
        int2_q    <= int2_d;
        int3_q    <= int3_d;
        dec_cnt_q <= dec_cnt_q + CNT_W'(1);
      end
      tick_q     <= accept_s && (dec_cnt_q == CNT_W'(DEC_RATE - 1));
      comb_vld_q <= tick_q;
      if (tick_q) begin
        comb_in_q <= int3_q;
      end
      if (comb_vld_q) begin
        dly1_q <= comb_in_q;
        dly2_q <= c1_s;
        dly3_q <= c2_s;
      end
    end
  end

  cic_out_fifo #(.W(OUT_W)) u_out_fifo (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clear_s),
    .push_i      (push_s),
    .push_data_i (c3_s),
    .ready_i     (dout_ready),
    .data_o      (dout),
    .valid_o     (dout_valid),
    .overflow_o  (overflow)
  );

endmodule
